// File: rtl/test_sink_checker.sv
// Self-checking stream sink: compares each accepted message against a preloaded
// expected-value table and reports pass/fail, error count and the first mismatch.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; expected table writable
//   RUN   | accepting messages (in_rdy=1) until num_msgs transfers seen
//   DONE  | result valid (done=1, pass, err_*); table writable; start re-arms
module test_sink_checker #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_msgs,
    input  logic              exp_wr_en,
    input  logic [ADDR_W-1:0] exp_wr_addr,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic [DATA_W-1:0] in_msg,
    input  logic              in_val,
    output logic              in_rdy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_index,
    output logic [DATA_W-1:0] err_got,
    output logic [DATA_W-1:0] err_exp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   limit;
    logic [DATA_W-1:0] table_mem [DEPTH];

    logic [ADDR_W:0]   start_len;
    logic [DATA_W-1:0] exp_cur;
    logic              mismatch;
    logic              last_xfer;
    logic              tbl_wr;
    logic [CNT_W-1:0]  err_count_nxt;

    // Oversized requests are clamped so the run never reads past the table.
    always_comb begin
        start_len = num_msgs;
        if (num_msgs > DEPTH_L)
            start_len = DEPTH_L;
    end

    assign in_rdy    = (state == RUN);
    assign exp_cur   = table_mem[index];
    // Case inequality: any X/Z bit in the received message is a mismatch.
    assign mismatch  = (in_msg !== exp_cur);
    assign last_xfer = ({1'b0, index} == (limit - (ADDR_W+1)'(1)));
    assign tbl_wr    = exp_wr_en && (state != RUN) && ({1'b0, exp_wr_addr} < DEPTH_L);

    always_comb begin
        err_count_nxt = err_count;
        if (mismatch && (err_count != CNT_MAX))
            err_count_nxt = err_count + CNT_W'(1);
    end

    // Table contents survive reset so a bench can reload only what changes.
    always_ff @(posedge clk) begin
        if (tbl_wr)
            table_mem[exp_wr_addr] <= exp_wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            limit     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            err_valid <= 1'b0;
            err_index <= '0;
            err_got   <= '0;
            err_exp   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        limit     <= start_len;
                        index     <= '0;
                        err_count <= '0;
                        err_valid <= 1'b0;
                        err_index <= '0;
                        err_got   <= '0;
                        err_exp   <= '0;
                        if (start_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= RUN;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (in_val) begin
                        index     <= index + ADDR_W'(1);
                        err_count <= err_count_nxt;
                        if (mismatch && !err_valid) begin
                            err_valid <= 1'b1;
                            err_index <= index;
                            err_got   <= in_msg;
                            err_exp   <= exp_cur;
                        end
                        if (last_xfer) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (err_count_nxt == '0);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_sink_checker.sv
// Directed bench for test_sink_checker: NOR truth-table runs, errors, stalls,
// X inputs, boundary lengths, start-in-run and reset abort.
module tb_test_sink_checker;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              clk_en = 1'b1;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_msgs = '0;
    logic              exp_wr_en = 1'b0;
    logic [ADDR_W-1:0] exp_wr_addr = '0;
    logic [DATA_W-1:0] exp_wr_data = '0;
    logic [DATA_W-1:0] in_msg = '0;
    logic              in_val = 1'b0;
    logic              in_rdy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic              err_valid;
    logic [ADDR_W-1:0] err_index;
    logic [DATA_W-1:0] err_got;
    logic [DATA_W-1:0] err_exp;

    int n_checks = 0;
    int n_fail   = 0;

    test_sink_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_msgs(num_msgs),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
        .done(done), .pass(pass), .err_count(err_count), .err_valid(err_valid),
        .err_index(err_index), .err_got(err_got), .err_exp(err_exp)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_exp(input int addr, input logic [DATA_W-1:0] data);
        exp_wr_en   = 1'b1;
        exp_wr_addr = ADDR_W'(addr);
        exp_wr_data = data;
        tick();
        exp_wr_en   = 1'b0;
    endtask

    task automatic load_nor();
        write_exp(0, 8'd1);
        write_exp(1, 8'd0);
        write_exp(2, 8'd0);
        write_exp(3, 8'd0);
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        num_msgs = (ADDR_W+1)'(n);
        tick();
        start    = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] msg);
        in_msg = msg;
        in_val = 1'b1;
        tick();
        in_val = 1'b0;
    endtask

    task automatic stall(input int cycles);
        in_val = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic test_reset();
        clk_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got=%b exp=0", pass); end
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_err_valid got=%b exp=0", err_valid); end
        #2;
        reset  = 1'b0;
        clk_en = 1'b1;
        tick();
    endtask

    task automatic test_nor_ok();
        load_nor();
        do_start(4);
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL ok_in_rdy_after_start got=%b exp=1", in_rdy); end
        send(8'd1); send(8'd0); send(8'd0);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ok_done_early got=%b exp=0", done); end
        send(8'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ok_done got=%b exp=1", done); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL ok_pass got=%b exp=1", pass); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL ok_err_count got=%0d exp=0", err_count); end
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL ok_in_rdy_done got=%b exp=0", in_rdy); end
    endtask

    task automatic test_two_errors();
        do_start(4);
        send(8'd1); send(8'd1); send(8'd0); send(8'd1);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL two_done got=%b exp=1", done); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL two_pass got=%b exp=0", pass); end
        n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL two_err_count got=%0d exp=2", err_count); end
        n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL two_err_valid got=%b exp=1", err_valid); end
        n_checks++; if (err_index !== 4'd1) begin n_fail++; $display("FAIL two_err_index got=%0d exp=1", err_index); end
        n_checks++; if (err_got !== 8'd1) begin n_fail++; $display("FAIL two_err_got got=%h exp=01", err_got); end
        n_checks++; if (err_exp !== 8'd0) begin n_fail++; $display("FAIL two_err_exp got=%h exp=00", err_exp); end
    endtask

    // Entry 2 is made nonzero so the X message mismatches on 2-state simulators too.
    task automatic test_stall_x();
        logic [DATA_W-1:0] x_msg;
        x_msg = 8'hxx;
        write_exp(2, 8'h5A);
        do_start(4);
        send(8'd1);
        stall(3);
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL stall_in_rdy got=%b exp=1", in_rdy); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL stall_err_count got=%0d exp=0", err_count); end
        send(8'd0);
        // Table writes during a run must be ignored; entry 3 stays 0.
        exp_wr_en = 1'b1; exp_wr_addr = 4'd3; exp_wr_data = 8'h55;
        stall(3);
        exp_wr_en = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done got=%b exp=0", done); end
        send(x_msg);
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL x_err_count got=%0d exp=1", err_count); end
        n_checks++; if (err_index !== 4'd2) begin n_fail++; $display("FAIL x_err_index got=%0d exp=2", err_index); end
        n_checks++; if (err_got !== x_msg) begin n_fail++; $display("FAIL x_err_got got=%h exp=%h", err_got, x_msg); end
        n_checks++; if (err_exp !== 8'h5A) begin n_fail++; $display("FAIL x_err_exp got=%h exp=5a", err_exp); end
        send(8'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_end_done got=%b exp=1", done); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL stall_end_err_count got=%0d exp=1 (run-time table write leaked)", err_count); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL stall_end_pass got=%b exp=0", pass); end
    endtask

    task automatic test_zero_msgs();
        do_start(0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got=%b exp=1", done); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL zero_pass got=%b exp=1", pass); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL zero_err_count got=%0d exp=0", err_count); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL zero_err_valid got=%b exp=0", err_valid); end
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL zero_in_rdy got=%b exp=0", in_rdy); end
    endtask

    task automatic test_start_in_run();
        write_exp(2, 8'd0);
        do_start(4);
        send(8'd1);
        start = 1'b1; num_msgs = '0;
        send(8'd0);
        start = 1'b0;
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL sir_in_rdy got=%b exp=1", in_rdy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL sir_done got=%b exp=0", done); end
        send(8'd0); send(8'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sir_end_done got=%b exp=1", done); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL sir_end_pass got=%b exp=1", pass); end
    endtask

    task automatic test_clamp();
        int accepted;
        for (int i = 0; i < DEPTH; i++) write_exp(i, DATA_W'(i * 3 + 1));
        do_start(20);
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            in_msg = DATA_W'(accepted * 3 + 1);
            in_val = 1'b1;
            if (in_rdy) accepted++;
            tick();
        end
        in_val = 1'b0;
        n_checks++; if (accepted !== 16) begin n_fail++; $display("FAIL clamp_transfers got=%0d exp=16", accepted); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clamp_done got=%b exp=1", done); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL clamp_pass got=%b exp=1", pass); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clamp_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_abort_restart();
        load_nor();
        do_start(4);
        send(8'd1); send(8'd1);
        reset = 1'b1;
        #1;
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL abort_in_rdy got=%b exp=0", in_rdy); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL abort_err_count got=%0d exp=0", err_count); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL abort_err_valid got=%b exp=0", err_valid); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_idle_done got=%b exp=0", done); end
        do_start(4);
        send(8'd1); send(8'd0); send(8'd0); send(8'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done got=%b exp=1", done); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL restart_pass got=%b exp=1", pass); end
    endtask

    initial begin
        test_reset();
        test_nor_ok();
        test_two_errors();
        test_reset();
        test_stall_x();
        test_zero_msgs();
        test_start_in_run();
        test_clamp();
        test_abort_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
